// File: rtl/serializer_stream_pkg.sv
// Shared types, constants and helpers for the flow-controlled word-to-bit serializer.
package serializer_stream_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StIdle  = 1'b0;
  localparam state_t StShift = 1'b1;

  localparam int unsigned DEFAULT_MIN_MOD = 3;

  // A bit count of zero selects the full word width.
  function automatic int unsigned decode_mod(input int unsigned mod, input int unsigned data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/serializer_hold.sv
// One-entry holding buffer for a pending word and its decoded bit count.
module serializer_hold #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [CNT_W-1:0]  wr_cnt_i,
  input  logic              rd_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  rd_cnt_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (wr_i) begin
      full_q <= 1'b1;
      data_q <= wr_data_i;
      cnt_q  <= wr_cnt_i;
    end else if (rd_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o    = full_q;
  assign rd_data_o = data_q;
  assign rd_cnt_o  = cnt_q;

endmodule

// File: rtl/serializer_stream.sv
// Serializes the low or high N bits of a word one per clock, with a one-word hold buffer
// for gapless back-to-back transfer and downstream backpressure.
module serializer_stream
  import serializer_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MOD_W     = $clog2(DATA_W),
  parameter int unsigned MIN_MOD   = DEFAULT_MIN_MOD,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  input  logic              ser_rdy_i,
  output logic              busy_o
);

  // One extra bit so a count of DATA_W is representable.
  localparam int unsigned CNT_W = MOD_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic              hold_full, hold_wr, hold_rd;
  logic [DATA_W-1:0] hold_data;
  logic [CNT_W-1:0]  hold_cnt;

  int unsigned       n_int;
  logic [CNT_W-1:0]  n;
  logic              legal, take, xfer, last;

  assign n_int = decode_mod(32'(data_mod_i), DATA_W);
  assign n     = CNT_W'(n_int);
  assign legal = (n_int >= MIN_MOD);
  assign take  = data_val_i && data_rdy_o && legal;
  assign xfer  = (state_q == StShift) && ser_rdy_i;
  assign last  = xfer && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    case (state_q)
      StIdle: begin
        if (take) begin
          shreg_d = data_i;
          cnt_d   = n;
          state_d = StShift;
        end
      end
      default: begin
        if (xfer) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q - CNT_W'(1);
        end
        if (last) begin
          // Held word wins; a fresh word can only arrive here when the buffer is empty.
          if (hold_full) begin
            hold_rd = 1'b1;
            shreg_d = hold_data;
            cnt_d   = hold_cnt;
          end else if (take) begin
            shreg_d = data_i;
            cnt_d   = n;
          end else begin
            state_d = StIdle;
          end
        end else if (take) begin
          hold_wr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  serializer_hold #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_hold (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .wr_i      (hold_wr),
    .wr_data_i (data_i),
    .wr_cnt_i  (n),
    .rd_i      (hold_rd),
    .flush_i   (1'b0),
    .full_o    (hold_full),
    .rd_data_o (hold_data),
    .rd_cnt_o  (hold_cnt)
  );

  assign ser_data_val_o = (state_q == StShift);
  assign ser_data_o     = ser_data_val_o &&
                          (MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0]);
  assign busy_o         = ser_data_val_o || hold_full;
  assign data_rdy_o     = !hold_full;

endmodule

// File: tb/tb_serializer_stream.sv
// Directed bench for serializer_stream: MSB-first main instance plus an LSB-first instance.
module tb_serializer_stream;

  logic        clk;
  logic        srst;
  logic [15:0] data;
  logic [3:0]  data_mod;
  logic        data_val;
  logic        data_rdy;
  logic        ser_data;
  logic        ser_val;
  logic        ser_rdy;
  logic        busy;

  logic [15:0] l_data;
  logic [3:0]  l_mod;
  logic        l_val;
  logic        l_rdy;
  logic        l_ser_data;
  logic        l_ser_val;
  logic        l_busy;

  int checks;
  int failures;

  serializer_stream #(
    .DATA_W    (16),
    .MOD_W     (4),
    .MIN_MOD   (3),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (data),
    .data_mod_i     (data_mod),
    .data_val_i     (data_val),
    .data_rdy_o     (data_rdy),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_val),
    .ser_rdy_i      (ser_rdy),
    .busy_o         (busy)
  );

  serializer_stream #(
    .DATA_W    (16),
    .MOD_W     (4),
    .MIN_MOD   (3),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk_i          (clk),
    .srst_i         (srst),
    .data_i         (l_data),
    .data_mod_i     (l_mod),
    .data_val_i     (l_val),
    .data_rdy_o     (l_rdy),
    .ser_data_o     (l_ser_data),
    .ser_data_val_o (l_ser_val),
    .ser_rdy_i      (1'b1),
    .busy_o         (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (ser_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", ser_val); end
    checks++;
    if (ser_data !== 1'b0) begin failures++; $display("FAIL reset_data got=%b exp=0", ser_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (data_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", data_rdy); end
  endtask

  // Two short words: 0xB800/3 -> 101, 0x5B82/6 -> 010110, first bit one cycle after accept.
  task automatic test_basic();
    logic [15:0] w [2];
    int          m [2];
    w[0] = 16'hB800; m[0] = 3;
    w[1] = 16'h5B82; m[1] = 6;
    for (int k = 0; k < 2; k++) begin
      data = w[k]; data_mod = 4'(m[k]); data_val = 1'b1;
      checks++;
      if (data_rdy !== 1'b1) begin failures++; $display("FAIL basic_rdy got=%b exp=1", data_rdy); end
      checks++;
      if (ser_val !== 1'b0) begin failures++; $display("FAIL basic_pre_val got=%b exp=0", ser_val); end
      step();
      data_val = 1'b0; data = 16'h0000; data_mod = 4'd0;
      for (int i = 0; i < m[k]; i++) begin
        checks++;
        if (ser_val !== 1'b1 || ser_data !== w[k][15-i]) begin
          failures++;
          $display("FAIL basic_bit w%0d i%0d got=%b/%b exp=1/%b", k, i, ser_val, ser_data,
                   w[k][15-i]);
        end
        step();
      end
      checks++;
      if (ser_val !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL basic_end val/busy got=%b/%b exp=0/0", ser_val, busy);
      end
    end
  endtask

  task automatic test_full_word();
    logic [15:0] w;
    int          cnt;
    w = 16'hA5C3;
    data = w; data_mod = 4'd0; data_val = 1'b1;
    step();
    data_val = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ser_val === 1'b1) begin
        checks++;
        if (cnt > 15 || ser_data !== w[15-(cnt & 15)]) begin
          failures++; $display("FAIL full_bit i%0d got=%b", cnt, ser_data);
        end
        cnt++;
      end
      step();
    end
    checks++;
    if (cnt != 16) begin failures++; $display("FAIL full_len got=%0d exp=16", cnt); end
  endtask

  task automatic test_short_drop();
    data = 16'hFFFF; data_mod = 4'd2; data_val = 1'b1;
    checks++;
    if (data_rdy !== 1'b1) begin failures++; $display("FAIL short_rdy got=%b exp=1", data_rdy); end
    step();
    data_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ser_val !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL short_quiet i%0d val/busy got=%b/%b exp=0/0", i, ser_val, busy);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp = 8'b1111_0000;
    data = 16'hF000; data_mod = 4'd4; data_val = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_val !== 1'b1 || ser_data !== exp[7-i]) begin
        failures++;
        $display("FAIL b2b_bit i%0d got=%b/%b exp=1/%b", i, ser_val, ser_data, exp[7-i]);
      end
      if (i == 0) begin
        data = 16'h0000; data_mod = 4'd4;
      end
      if (i == 1) begin
        checks++;
        if (data_rdy !== 1'b0) begin failures++; $display("FAIL b2b_hold_rdy got=%b exp=0", data_rdy); end
        data_val = 1'b0;
      end
      if (i == 4) begin
        checks++;
        if (data_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy_back got=%b exp=1", data_rdy); end
      end
      step();
    end
    checks++;
    if (ser_val !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_end val/busy got=%b/%b exp=0/0", ser_val, busy);
    end
  endtask

  // 0xB800/5 -> 10111, stalled for 5 cycles while the second bit is presented.
  task automatic test_backpressure();
    logic [4:0] exp;
    exp = 5'b10111;
    data = 16'hB800; data_mod = 4'd5; data_val = 1'b1;
    step();
    data_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ser_val !== 1'b1 || ser_data !== exp[4-i]) begin
        failures++;
        $display("FAIL bp_bit i%0d got=%b/%b exp=1/%b", i, ser_val, ser_data, exp[4-i]);
      end
      if (i == 1) begin
        ser_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          checks++;
          if (ser_val !== 1'b1 || ser_data !== 1'b0) begin
            failures++; $display("FAIL bp_stall s%0d got=%b/%b exp=1/0", s, ser_val, ser_data);
          end
        end
        ser_rdy = 1'b1;
      end
      step();
    end
    checks++;
    if (ser_val !== 1'b0) begin failures++; $display("FAIL bp_end got=%b exp=0", ser_val); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int         seen;
    exp = 8'hC3;
    data = 16'hC300; data_mod = 4'd8; data_val = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ser_val !== 1'b1 || ser_data !== exp[7-i]) begin
        failures++;
        $display("FAIL rst_mid_bit i%0d got=%b/%b exp=1/%b", i, ser_val, ser_data, exp[7-i]);
      end
      if (i == 0) data = 16'hFFFF;
      if (i == 1) begin
        data_val = 1'b0;
        checks++;
        if (data_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%b exp=0", data_rdy); end
      end
      if (i == 3) srst = 1'b1;
      step();
    end
    srst = 1'b0;
    checks++;
    if (ser_val !== 1'b0 || ser_data !== 1'b0 || busy !== 1'b0 || data_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_out val/data/busy/rdy got=%b%b%b%b exp=0001", ser_val, ser_data,
               busy, data_rdy);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ser_val !== 1'b0 || busy !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rst_mid_quiet got=%0d exp=0", seen); end
  endtask

  task automatic test_lsb_first();
    logic [2:0] exp;
    exp = 3'b101;
    l_data = 16'h0005; l_mod = 4'd3; l_val = 1'b1;
    step();
    l_val = 1'b0; l_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (l_ser_val !== 1'b1 || l_ser_data !== exp[2-i]) begin
        failures++;
        $display("FAIL lsb_bit i%0d got=%b/%b exp=1/%b", i, l_ser_val, l_ser_data, exp[2-i]);
      end
      step();
    end
    checks++;
    if (l_ser_val !== 1'b0 || l_busy !== 1'b0 || l_rdy !== 1'b1) begin
      failures++; $display("FAIL lsb_end val/busy/rdy got=%b%b%b exp=001", l_ser_val, l_busy, l_rdy);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    srst = 1'b1; data = '0; data_mod = '0; data_val = 1'b0; ser_rdy = 1'b1;
    l_data = '0; l_mod = '0; l_val = 1'b0;
    step();
    step();
    srst = 1'b0;
    test_reset();
    test_basic();
    test_full_word();
    test_short_drop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
